// File: rtl/rd_burst_pkg.sv
// Shared state encoding and default parameters for the read-burst sequencer.
package rd_burst_pkg;

   localparam int unsigned DW_DEF    = 8;
   localparam int unsigned DEPTH_DEF = 4;
   localparam int unsigned TMO_DEF   = 15;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StFin,
      StErr
   } state_e;

endpackage

// File: rtl/rd_fifo.sv
// Synchronous FIFO holding returned read words until the consumer takes them.
module rd_fifo #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [DW-1:0]              i_wdata,
   output logic [DW-1:0]              o_rdata,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_full,
   output logic                       o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          w_wr;
   logic          w_rd;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rptr];
   assign w_wr    = i_push && !o_full;
   assign w_rd    = i_pop && !o_empty;

   // Storage needs no reset; validity is tracked by r_count alone.
   always_ff @(posedge i_clk) begin
      if (w_wr) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + AW'(1);
         if (w_rd) r_rptr <= r_rptr + AW'(1);
         if (w_wr && !w_rd) begin
            r_count <= r_count + CW'(1);
         end else if (!w_wr && w_rd) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

endmodule

// File: rtl/rd_burst_seq.sv
// Issues a burst of single outstanding reads, buffers returned words in a FIFO,
// and aborts with a sticky error if the reader stops answering.
module rd_burst_seq
   import rd_burst_pkg::*;
#(
   parameter int unsigned DW    = DW_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned TMO   = TMO_DEF
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic [3:0]    i_burst_len,
   output logic          o_go,
   input  logic          i_ds,
   input  logic [DW-1:0] i_rdata,
   output logic          o_out_vld,
   output logic [DW-1:0] o_out_data,
   input  logic          i_out_rdy,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_tmo_err
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned TW = $clog2(TMO + 1);

   state_e        r_state;
   state_e        w_next;
   logic [3:0]    r_len;
   logic [3:0]    r_cnt;
   logic [TW-1:0] r_tmo;
   logic          r_ds;
   logic [DW-1:0] r_rdata;
   logic          r_tmo_err;
   logic          r_zdone;

   logic          w_accept;
   logic          w_last;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic [DW-1:0] w_head;

   assign w_accept = (r_state == StIdle) && i_start;
   assign w_last   = ((r_cnt + 4'd1) == r_len);
   assign w_push   = (r_state == StWait) && r_ds;
   assign w_pop    = !w_empty && i_out_rdy;

   rd_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (r_rdata),
      .o_rdata (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         StIdle:  if (i_start && (i_burst_len != 4'd0)) w_next = StIssue;
         StIssue: if (!w_full) w_next = StWait;
         StWait: begin
            // A strobe arriving on the last allowed cycle still counts as an answer.
            if (r_ds) begin
               w_next = w_last ? StFin : StIssue;
            end else if ((r_tmo >= TW'(TMO - 1)) && !i_ds) begin
               w_next = StErr;
            end
         end
         StFin:   w_next = StIdle;
         StErr:   w_next = StIdle;
         default: w_next = StIdle;
      endcase
   end

   // ds is registered (and gated to WAIT) so the next launch lands two cycles after it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_len     <= '0;
         r_cnt     <= '0;
         r_tmo     <= '0;
         r_ds      <= 1'b0;
         r_rdata   <= '0;
         r_tmo_err <= 1'b0;
         r_zdone   <= 1'b0;
      end else begin
         r_ds    <= i_ds && (r_state == StWait);
         r_zdone <= w_accept && (i_burst_len == 4'd0);
         if (i_ds && (r_state == StWait)) r_rdata <= i_rdata;
         if (w_accept) begin
            r_len     <= i_burst_len;
            r_cnt     <= '0;
            r_tmo_err <= 1'b0;
         end
         if (w_push) r_cnt <= r_cnt + 4'd1;
         if (r_state != StWait) begin
            r_tmo <= '0;
         end else if (!r_ds) begin
            r_tmo <= r_tmo + TW'(1);
         end
         if ((r_state == StWait) && (w_next == StErr)) r_tmo_err <= 1'b1;
      end
   end

   always_comb begin
      o_go       = (r_state == StIssue) && (w_count < CW'(DEPTH));
      o_busy     = (r_state != StIdle);
      o_done     = (r_state == StFin) || r_zdone;
      o_tmo_err  = r_tmo_err;
      o_out_vld  = !w_empty;
      o_out_data = w_head;
   end

endmodule

// File: tb/tb_rd_burst_seq.sv
// Bench for rd_burst_seq: directed scenarios plus random bursts against a
// queue-based model of the reader and the expected output word stream.
module tb_rd_burst_seq;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned TMO   = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [3:0]    burst_len;
   logic          go;
   logic          ds;
   logic [DW-1:0] rdata;
   logic          out_vld;
   logic [DW-1:0] out_data;
   logic          out_rdy;
   logic          busy;
   logic          done;
   logic          tmo_err;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   // Reader model and observation history.
   int            rd_delay = 3;
   int            rd_wait = 0;
   int            rd_allow = 0;
   bit            rd_seq = 0;
   int            rd_idx = 0;
   bit            stray_ds = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_q[$];
   int            go_cyc[$];
   int            ds_cyc[$];
   int            n_go = 0;
   int            n_done = 0;
   int            done_cyc = -1;

   always #5 clk = ~clk;

   rd_burst_seq #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .TMO   (TMO)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_burst_len (burst_len),
      .o_go        (go),
      .i_ds        (ds),
      .i_rdata     (rdata),
      .o_out_vld   (out_vld),
      .o_out_data  (out_data),
      .i_out_rdy   (out_rdy),
      .o_busy      (busy),
      .o_done      (done),
      .o_tmo_err   (tmo_err)
   );

   // One clock cycle: reader answers, outputs are observed, then the edge.
   task automatic step();
      ds = 1'b0;
      if (rd_wait > 0) begin
         rd_wait--;
         if (rd_wait == 0 && rd_allow > 0) begin
            rd_allow--;
            ds    = 1'b1;
            rdata = rd_seq ? (8'hA0 + 8'(rd_idx)) : 8'($urandom);
            rd_idx++;
            exp_q.push_back(rdata);
            ds_cyc.push_back(cyc);
         end
      end
      if (stray_ds) begin
         ds       = 1'b1;
         rdata    = 8'($urandom);
         stray_ds = 0;
      end
      if (go === 1'b1) begin
         n_go++;
         go_cyc.push_back(cyc);
         rd_wait = rd_delay;
      end
      if (done === 1'b1) begin
         n_done++;
         done_cyc = cyc;
      end
      if (out_vld === 1'b1 && out_rdy === 1'b1) got_q.push_back(out_data);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_hist();
      exp_q.delete();
      got_q.delete();
      go_cyc.delete();
      ds_cyc.delete();
      n_go     = 0;
      n_done   = 0;
      done_cyc = -1;
      rd_idx   = 0;
      rd_wait  = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      n_vec++;
      if ({go, done, busy, tmo_err, out_vld} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_outputs: go,done,busy,tmo_err,vld=%b want 00000",
                  {go, done, busy, tmo_err, out_vld});
      end
      step();
      n_vec++;
      if ({go, busy, out_vld} !== 3'b0) begin
         n_err++;
         $display("FAIL reset_idle: go,busy,vld=%b want 000", {go, busy, out_vld});
      end
   endtask

   task automatic test_burst3();
      bit idle = 0;
      clear_hist();
      rd_delay = 3; rd_allow = 3; rd_seq = 1; out_rdy = 1'b1;
      start = 1'b1; burst_len = 4'd3; step(); start = 1'b0;
      for (int i = 0; i < 100 && !idle; i++) begin
         step();
         if (!busy) idle = 1;
      end
      n_vec++;
      if (!idle) begin n_err++; $display("FAIL burst3_end: busy=%b want 0", busy); end
      n_vec++;
      if (cyc != done_cyc + 1) begin
         n_err++;
         $display("FAIL burst3_busy_after_fin: idle cycle %0d want %0d", cyc, done_cyc + 1);
      end
      repeat (2) step();
      n_vec++;
      if (n_go != 3) begin n_err++; $display("FAIL burst3_go: got %0d want 3", n_go); end
      n_vec++;
      if (n_done != 1) begin n_err++; $display("FAIL burst3_done: got %0d want 1", n_done); end
      n_vec++;
      if (got_q.size() != 3) begin
         n_err++;
         $display("FAIL burst3_pops: got %0d want 3", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < 3; i++) begin
         n_vec++;
         if (got_q[i] !== 8'hA0 + 8'(i)) begin
            n_err++;
            $display("FAIL burst3_data%0d: got %h want %h", i, got_q[i], 8'hA0 + 8'(i));
         end
      end
      if (go_cyc.size() == 3 && ds_cyc.size() == 3) begin
         for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (go_cyc[i+1] - ds_cyc[i] != 2) begin
               n_err++;
               $display("FAIL burst3_latency%0d: got %0d want 2", i, go_cyc[i+1] - ds_cyc[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit idle = 0;
      clear_hist();
      rd_delay = 2; rd_allow = 6; rd_seq = 0; out_rdy = 1'b0;
      start = 1'b1; burst_len = 4'd6; step(); start = 1'b0;
      repeat (40) step();
      n_vec++;
      if (n_go != DEPTH) begin n_err++; $display("FAIL bp_go_held: got %0d want 4", n_go); end
      n_vec++;
      if ({busy, go, out_vld} !== 3'b101) begin
         n_err++;
         $display("FAIL bp_hold_state: busy,go,vld=%b want 101", {busy, go, out_vld});
      end
      out_rdy = 1'b1;
      for (int i = 0; i < 100 && !idle; i++) begin
         step();
         if (!busy) idle = 1;
      end
      repeat (4) step();
      n_vec++;
      if (n_go != 6 || n_done != 1) begin
         n_err++;
         $display("FAIL bp_complete: go=%0d done=%0d want 6 and 1", n_go, n_done);
      end
      n_vec++;
      if (got_q.size() != 6) begin
         n_err++;
         $display("FAIL bp_pops: got %0d want 6", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_vec++;
         if (got_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL bp_data%0d: got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_timeout();
      bit reached = 0;
      bit idle = 0;
      logic mid = 1'bx;
      clear_hist();
      rd_delay = 3; rd_allow = 1; rd_seq = 0; out_rdy = 1'b0;
      start = 1'b1; burst_len = 4'd2; step(); start = 1'b0;
      for (int i = 0; i < 60 && !reached; i++) begin
         step();
         if (n_go == 2) reached = 1;
      end
      n_vec++;
      if (!reached) begin n_err++; $display("FAIL tmo_second_go: got %0d gos want 2", n_go); end
      if (reached) begin
         for (int i = 0; i < 40 && !idle; i++) begin
            if (cyc == go_cyc[1] + TMO) mid = tmo_err;
            if (!busy) idle = 1;
            else step();
         end
         n_vec++;
         if (cyc != go_cyc[1] + TMO + 2) begin
            n_err++;
            $display("FAIL tmo_idle_cycle: got %0d want %0d", cyc, go_cyc[1] + TMO + 2);
         end
         n_vec++;
         if (mid !== 1'b0) begin n_err++; $display("FAIL tmo_err_early: got %b want 0", mid); end
      end
      n_vec++;
      if (tmo_err !== 1'b1) begin n_err++; $display("FAIL tmo_err_set: got %b want 1", tmo_err); end
      n_vec++;
      if (n_done != 0) begin n_err++; $display("FAIL tmo_no_done: got %0d want 0", n_done); end
      n_vec++;
      if (out_vld !== 1'b1 || exp_q.size() != 1 || out_data !== exp_q[0]) begin
         n_err++;
         $display("FAIL tmo_word: vld=%b data=%h want 1 and first returned word", out_vld, out_data);
      end
      out_rdy = 1'b1; step(); out_rdy = 1'b0;
      repeat (3) step();
      n_vec++;
      if (out_vld !== 1'b0 || tmo_err !== 1'b1) begin
         n_err++;
         $display("FAIL tmo_single_sticky: vld=%b tmo_err=%b want 0 and 1", out_vld, tmo_err);
      end
   endtask

   task automatic test_zero_len();
      clear_hist();
      start = 1'b1; burst_len = 4'd0; step(); start = 1'b0;
      n_vec++;
      if ({done, busy, tmo_err} !== 3'b100) begin
         n_err++;
         $display("FAIL zero_done_pulse: done,busy,tmo_err=%b want 100", {done, busy, tmo_err});
      end
      step();
      n_vec++;
      if ({done, busy} !== 2'b00) begin
         n_err++;
         $display("FAIL zero_done_once: done,busy=%b want 00", {done, busy});
      end
      repeat (3) step();
      n_vec++;
      if (n_go != 0 || n_done != 1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL zero_no_go: go=%0d done=%0d busy=%b want 0 1 0", n_go, n_done, busy);
      end
   endtask

   task automatic test_reset_mid();
      bit reached = 0;
      clear_hist();
      rd_delay = 3; rd_allow = 5; rd_seq = 0; out_rdy = 1'b0;
      start = 1'b1; burst_len = 4'd5; step(); start = 1'b0;
      for (int i = 0; i < 60 && !reached; i++) begin
         step();
         if (n_go == 3) reached = 1;
      end
      n_vec++;
      if (!reached || out_vld !== 1'b1 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL rstmid_setup: gos=%0d vld=%b busy=%b want 3 1 1", n_go, out_vld, busy);
      end
      rst = 1'b1; stray_ds = 1; step(); rst = 1'b0;
      rd_wait = 0; rd_allow = 0; exp_q.delete();
      n_vec++;
      if ({out_vld, busy, go, done, tmo_err} !== 5'b0) begin
         n_err++;
         $display("FAIL rstmid_cleared: vld,busy,go,done,tmo=%b want 00000",
                  {out_vld, busy, go, done, tmo_err});
      end
      stray_ds = 1; step();
      repeat (3) step();
      n_vec++;
      if (out_vld !== 1'b0 || busy !== 1'b0 || n_go != 3) begin
         n_err++;
         $display("FAIL rstmid_ds_ignored: vld=%b busy=%b gos=%0d want 0 0 3", out_vld, busy, n_go);
      end
   endtask

   task automatic test_ignored();
      bit reached = 0;
      bit idle = 0;
      clear_hist();
      out_rdy = 1'b0; stray_ds = 1; step();
      repeat (2) step();
      n_vec++;
      if (out_vld !== 1'b0) begin n_err++; $display("FAIL ign_idle_ds: vld=%b want 0", out_vld); end
      rd_delay = 4; rd_allow = 2; rd_seq = 1; out_rdy = 1'b1;
      start = 1'b1; burst_len = 4'd2; step(); start = 1'b0;
      for (int i = 0; i < 20 && !reached; i++) begin
         step();
         if (n_go == 1) reached = 1;
      end
      start = 1'b1; burst_len = 4'd7; step(); start = 1'b0;
      for (int i = 0; i < 100 && !idle; i++) begin
         step();
         if (!busy) idle = 1;
      end
      repeat (6) step();
      n_vec++;
      if (!reached || n_go != 2 || n_done != 1) begin
         n_err++;
         $display("FAIL ign_burst: gos=%0d done=%0d want 2 and 1", n_go, n_done);
      end
      n_vec++;
      if (got_q.size() != 2) begin
         n_err++;
         $display("FAIL ign_pops: got %0d want 2", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < 2; i++) begin
         n_vec++;
         if (got_q[i] !== 8'hA0 + 8'(i)) begin
            n_err++;
            $display("FAIL ign_data%0d: got %h want %h", i, got_q[i], 8'hA0 + 8'(i));
         end
      end
   endtask

   task automatic test_random();
      for (int b = 0; b < 12; b++) begin
         bit idle = 0;
         int len = int'($urandom_range(1, 8));
         clear_hist();
         rd_delay = int'($urandom_range(1, 6)); rd_allow = len; rd_seq = 0;
         out_rdy = 1'b1;
         start = 1'b1; burst_len = 4'(len); step(); start = 1'b0;
         for (int i = 0; i < 400 && !idle; i++) begin
            out_rdy = ($urandom_range(0, 3) != 0);
            step();
            if (!busy) idle = 1;
         end
         out_rdy = 1'b1;
         repeat (8) step();
         n_vec++;
         if (n_go != len || n_done != 1 || tmo_err !== 1'b0) begin
            n_err++;
            $display("FAIL rand%0d_ctrl: gos=%0d done=%0d tmo=%b want %0d 1 0",
                     b, n_go, n_done, tmo_err, len);
         end
         n_vec++;
         if (got_q.size() != len) begin
            n_err++;
            $display("FAIL rand%0d_pops: got %0d want %0d", b, got_q.size(), len);
         end
         for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
               n_err++;
               $display("FAIL rand%0d_data%0d: got %h want %h", b, i, got_q[i], exp_q[i]);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; burst_len = 4'd0;
      ds = 1'b0; rdata = '0; out_rdy = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_burst3();
      test_backpressure();
      test_timeout();
      test_zero_len();
      test_reset_mid();
      test_ignored();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
